// File: rtl/tow_match_controller.sv
// Best-of-N tug-of-war match sequencer: gates presses, clears field, scores rounds.
// Ports: clk, reset(async low), start, l/r_press, l/r_round_won -> l/r_play,
//   field_clear, l/r_score[3:0], match_over, match_winner. Option: TOW_FALSE_START_EN.
module tow_match_controller #(
  parameter int WIN_ROUNDS   = 3,
  parameter int PAUSE_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       l_press,
  input  logic       r_press,
  input  logic       l_round_won,
  input  logic       r_round_won,
  output logic       l_play,
  output logic       r_play,
  output logic       field_clear,
  output logic [3:0] l_score,
  output logic [3:0] r_score,
  output logic       match_over,
  output logic       match_winner
);

  localparam int CW = $clog2(PAUSE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PAUSE_CYCLES - 1);
  localparam logic [3:0] WIN = 4'(WIN_ROUNDS);

  typedef enum logic [2:0] {
    IDLE, CLEAR, PLAY, PAUSE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    l_q, l_d, r_q, r_d;
  logic          win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    l_inc, r_inc;
  logic          fs_l, fs_r;

  assign l_inc = l_q + 4'd1;
  assign r_inc = r_q + 4'd1;

  // fs_l: left is awarded a round because right jumped the gun (and vice versa)
`ifdef TOW_FALSE_START_EN
  assign fs_l = r_press & ~l_press;
  assign fs_r = l_press & ~r_press;
`else
  assign fs_l = 1'b0;
  assign fs_r = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      win_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start) state_d = CLEAR;
      CLEAR: state_d = PLAY;
      PLAY: begin
        if (l_round_won && !r_round_won) begin
          l_d = l_inc;
          if (l_inc == WIN) begin
            state_d = DONE;
            win_d   = 1'b0;
          end else begin
            state_d = PAUSE;
            cnt_d   = RELOAD;
          end
        end else if (r_round_won && !l_round_won) begin
          r_d = r_inc;
          if (r_inc == WIN) begin
            state_d = DONE;
            win_d   = 1'b1;
          end else begin
            state_d = PAUSE;
            cnt_d   = RELOAD;
          end
        end else if (l_round_won && r_round_won) begin
          state_d = PAUSE;
          cnt_d   = RELOAD;
        end
      end
      PAUSE: begin
        if (fs_l) begin
          l_d = l_inc;
          if (l_inc == WIN) begin
            state_d = DONE;
            win_d   = 1'b0;
          end else begin
            cnt_d = RELOAD;
          end
        end else if (fs_r) begin
          r_d = r_inc;
          if (r_inc == WIN) begin
            state_d = DONE;
            win_d   = 1'b1;
          end else begin
            cnt_d = RELOAD;
          end
        end else if (cnt_q == '0) begin
          state_d = CLEAR;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          l_d     = '0;
          r_d     = '0;
          state_d = CLEAR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign l_play       = l_press & (state_q == PLAY);
  assign r_play       = r_press & (state_q == PLAY);
  assign field_clear  = (state_q == CLEAR);
  assign match_over   = (state_q == DONE);
  assign match_winner = match_over & win_q;
  assign l_score      = l_q;
  assign r_score      = r_q;

endmodule
